// File: rtl/sync_mem_bank.sv
// Single-port synchronous data memory with a valid/ready request port, per-bit write mask,
// a registered read response, and a sweep that fills every word with INIT_VAL after reset or on command.
module sync_mem_bank #(
  parameter int                 DATA_W   = 8,
  parameter int                 DEPTH    = 64,
  parameter logic [DATA_W-1:0]  INIT_VAL = '0
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       clear,
  input  logic                       req_valid,
  output logic                       req_ready,
  input  logic                       req_we,
  input  logic [$clog2(DEPTH)-1:0]   req_addr,
  input  logic [DATA_W-1:0]          req_wdata,
  input  logic [DATA_W-1:0]          req_wmask,
  output logic                       rsp_valid,
  output logic [DATA_W-1:0]          rsp_rdata,
  output logic                       rsp_err,
  output logic                       busy
);

  localparam int            AW   = $clog2(DEPTH);
  localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);

  typedef enum logic {S_CLEAR = 1'b0, S_IDLE = 1'b1} state_t;

  state_t              state_q, state_d;
  logic [AW-1:0]       ptr_q, ptr_d;
  logic                rsp_valid_q, rsp_valid_d;
  logic                rsp_err_q, rsp_err_d;
  logic [DATA_W-1:0]   rsp_rdata_q, rsp_rdata_d;
  logic [DATA_W-1:0]   mem_q [DEPTH];
  logic                clr_we, wr_we, in_range;

  // Address checking only exists when some addresses fall outside the array.
  generate
    if (DEPTH == (1 << AW)) begin : g_pow2
      assign in_range = 1'b1;
    end else begin : g_npow2
      assign in_range = ({1'b0, req_addr} < (AW+1)'(DEPTH));
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_CLEAR;
      ptr_q       <= '0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_rdata_q <= '0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_err_q   <= rsp_err_d;
      rsp_rdata_q <= rsp_rdata_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    rsp_valid_d = 1'b0;
    rsp_err_d   = 1'b0;
    rsp_rdata_d = rsp_rdata_q;
    clr_we      = 1'b0;
    wr_we       = 1'b0;
    case (state_q)
      S_CLEAR: begin
        clr_we = 1'b1;
        ptr_d  = ptr_q + AW'(1);
        if (ptr_q == LAST) begin
          state_d = S_IDLE;
          ptr_d   = '0;
        end
      end
      S_IDLE: begin
        if (clear) begin
          state_d = S_CLEAR;
          ptr_d   = '0;
        end else if (req_valid) begin
          rsp_valid_d = 1'b1;
          if (!in_range)   rsp_err_d   = 1'b1;
          else if (req_we) wr_we       = 1'b1;
          else             rsp_rdata_d = mem_q[req_addr];
        end
      end
      default: state_d = S_CLEAR;
    endcase
  end

  // Storage has no reset; the sweep is held off while rst is high so it restarts cleanly.
  always_ff @(posedge clk) begin
    if (clr_we && !rst) begin
      mem_q[ptr_q] <= INIT_VAL;
    end else if (wr_we) begin
      mem_q[req_addr] <= (mem_q[req_addr] & ~req_wmask) | (req_wdata & req_wmask);
    end
  end

  assign req_ready = (state_q == S_IDLE) && !clear;
  assign busy      = (state_q == S_CLEAR);
  assign rsp_valid = rsp_valid_q;
  assign rsp_err   = rsp_err_q;
  assign rsp_rdata = rsp_rdata_q;

endmodule
